// File: rtl/vga_timing_if.sv
// Raster bus between the VGA timing generator and the pixel/render pipeline.
// The generator drives the raster position and sync/strobe outputs; the consumer drives pix_en.
interface vga_timing_if #(
  parameter int CNT_W   = 16,
  parameter int FRAME_W = 8
);
  logic               pix_en;
  logic [CNT_W-1:0]   h_count;
  logic [CNT_W-1:0]   v_count;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  pix_en,
    output h_count, v_count, hsync, vsync, video_on,
    output line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  h_count, v_count, hsync, vsync, video_on,
    input  line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: H/V counters, sync and visible-area decode,
// line/frame strobes and a frame counter, all registered and advanced by pix_en.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 16,
  parameter int FRAME_W    = 8
) (
  input  logic          clk_25MHz,
  input  logic          rst_n,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 32'd1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 32'd1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be at least 1");
    end
    if ((longint'(H_TOTAL) - 64'sd1) >= (64'sd1 <<< CNT_W) ||
        (longint'(V_TOTAL) - 64'sd1) >= (64'sd1 <<< CNT_W)) begin : g_bad_width
      $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits");
    end
  endgenerate

  logic [CNT_W-1:0]   h_count_r;
  logic [CNT_W-1:0]   v_count_r;
  logic               hsync_r;
  logic               vsync_r;
  logic               video_on_r;
  logic               line_start_r;
  logic               frame_start_r;
  logic [FRAME_W-1:0] frame_count_r;

  logic [CNT_W-1:0]   h_next_s;
  logic [CNT_W-1:0]   v_next_s;
  logic               hsync_next_s;
  logic               vsync_next_s;
  logic               video_on_next_s;
  logic               line_start_next_s;
  logic               frame_start_next_s;

  // Next raster position and the decode of that position, so the registered
  // outputs always match the counters they are loaded alongside.
  always_comb begin
    h_next_s           = h_count_r + CNT_ONE;
    v_next_s           = v_count_r;
    hsync_next_s       = ~H_SYNC_POL;
    vsync_next_s       = ~V_SYNC_POL;
    video_on_next_s    = 1'b0;
    line_start_next_s  = 1'b0;
    frame_start_next_s = 1'b0;

    if (h_count_r == H_LAST) begin
      h_next_s = CNT_ZERO;
      if (v_count_r == V_LAST) begin
        v_next_s = CNT_ZERO;
      end else begin
        v_next_s = v_count_r + CNT_ONE;
      end
    end else begin
      v_next_s = v_count_r;
    end

    if ((h_next_s >= H_SYNC_BEG) && (h_next_s < H_SYNC_END)) begin
      hsync_next_s = H_SYNC_POL;
    end else begin
      hsync_next_s = ~H_SYNC_POL;
    end

    if ((v_next_s >= V_SYNC_BEG) && (v_next_s < V_SYNC_END)) begin
      vsync_next_s = V_SYNC_POL;
    end else begin
      vsync_next_s = ~V_SYNC_POL;
    end

    video_on_next_s    = (h_next_s < H_VIS_END) && (v_next_s < V_VIS_END);
    line_start_next_s  = (h_next_s == CNT_ZERO);
    frame_start_next_s = (h_next_s == CNT_ZERO) && (v_next_s == CNT_ZERO);
  end

  // Raster state; strobes drop whenever pix_en is low so they never stretch.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_count_r     <= H_LAST;
      v_count_r     <= V_LAST;
      hsync_r       <= ~H_SYNC_POL;
      vsync_r       <= ~V_SYNC_POL;
      video_on_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= {FRAME_W{1'b1}};
    end else begin
      line_start_r  <= vga.pix_en & line_start_next_s;
      frame_start_r <= vga.pix_en & frame_start_next_s;
      if (vga.pix_en) begin
        h_count_r  <= h_next_s;
        v_count_r  <= v_next_s;
        hsync_r    <= hsync_next_s;
        vsync_r    <= vsync_next_s;
        video_on_r <= video_on_next_s;
        if (frame_start_next_s) begin
          frame_count_r <= frame_count_r + FRAME_W'(32'd1);
        end
      end
    end
  end

  assign vga.h_count     = h_count_r;
  assign vga.v_count     = v_count_r;
  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.video_on    = video_on_r;
  assign vga.line_start  = line_start_r;
  assign vga.frame_start = frame_start_r;
  assign vga.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three parameter sets on one clock, a
// hand-written vector table, and an arithmetic raster model checked every cycle.
module tb_vga_timing_gen;

  typedef struct packed {
    int h; int v; bit hs; bit vs; bit vo; bit ls; bit fs; int fc;
  } obs_t;

  typedef struct packed {
    int hv; int hf; int hsw; int hb; int vv; int vf; int vsw; int vb; bit hp; bit vp;
  } cfg_t;

  typedef struct {
    bit   rst_n;
    bit   pix_en;
    obs_t exp;
  } vec_t;

  localparam cfg_t CFG_D = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t CFG_M = '{4, 1, 2, 1, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t CFG_S = '{4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1};

  logic  clk_25MHz = 1'b0;
  logic  rst_n     = 1'b0;
  logic  pix_en_s  = 1'b0;
  int    n_checks  = 0;
  int    n_fails   = 0;
  longint k_r      = 0;
  bit    adv_r     = 1'b0;
  vec_t  vecs[12];

  always #5 clk_25MHz = ~clk_25MHz;

  vga_timing_if #(.CNT_W(16), .FRAME_W(8)) if_d ();
  vga_timing_if #(.CNT_W(16), .FRAME_W(8)) if_m ();
  vga_timing_if #(.CNT_W(16), .FRAME_W(8)) if_s ();

  assign if_d.pix_en = pix_en_s;
  assign if_m.pix_en = pix_en_s;
  assign if_s.pix_en = pix_en_s;

  vga_timing_gen dut_d (.clk_25MHz(clk_25MHz), .rst_n(rst_n), .vga(if_d));

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)
  ) dut_m (.clk_25MHz(clk_25MHz), .rst_n(rst_n), .vga(if_m));

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_s (.clk_25MHz(clk_25MHz), .rst_n(rst_n), .vga(if_s));

  // Reference bookkeeping: number of advances since reset and whether the last edge advanced.
  always @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      k_r   <= 0;
      adv_r <= 1'b0;
    end else begin
      adv_r <= pix_en_s;
      if (pix_en_s) k_r <= k_r + 1;
    end
  end

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit vo, bit ls, bit fs, int fc);
    obs_t o;
    o.h = h; o.v = v; o.hs = hs; o.vs = vs; o.vo = vo; o.ls = ls; o.fs = fs; o.fc = fc;
    return o;
  endfunction

  // Raster position as a flat index into the frame, counted from the first advance.
  function automatic obs_t model(cfg_t c, longint k, bit adv);
    longint ht, vt, ft, idx;
    obs_t o;
    ht = c.hv + c.hf + c.hsw + c.hb;
    vt = c.vv + c.vf + c.vsw + c.vb;
    ft = ht * vt;
    if (k == 0) begin
      o = mk(int'(ht - 1), int'(vt - 1), !c.hp, !c.vp, 1'b0, 1'b0, 1'b0, 255);
    end else begin
      idx  = (k - 1) % ft;
      o.h  = int'(idx % ht);
      o.v  = int'(idx / ht);
      o.hs = (o.h >= c.hv + c.hf && o.h < c.hv + c.hf + c.hsw) ? c.hp : !c.hp;
      o.vs = (o.v >= c.vv + c.vf && o.v < c.vv + c.vf + c.vsw) ? c.vp : !c.vp;
      o.vo = (o.h < c.hv) && (o.v < c.vv);
      o.ls = adv && (o.h == 0);
      o.fs = adv && (idx == 0);
      o.fc = int'(((k - 1) / ft) % 256);
    end
    return o;
  endfunction

  function automatic obs_t obs_d();
    return mk(int'(if_d.h_count), int'(if_d.v_count), if_d.hsync, if_d.vsync, if_d.video_on,
              if_d.line_start, if_d.frame_start, int'(if_d.frame_count));
  endfunction

  function automatic obs_t obs_m();
    return mk(int'(if_m.h_count), int'(if_m.v_count), if_m.hsync, if_m.vsync, if_m.video_on,
              if_m.line_start, if_m.frame_start, int'(if_m.frame_count));
  endfunction

  function automatic obs_t obs_s();
    return mk(int'(if_s.h_count), int'(if_s.v_count), if_s.hsync, if_s.vsync, if_s.video_on,
              if_s.line_start, if_s.frame_start, int'(if_s.frame_count));
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b fc=%0d, expected h=%0d v=%0d hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b fc=%0d",
               name, $time, act.h, act.v, act.hs, act.vs, act.vo, act.ls, act.fs, act.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic check_int(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check_obs("model_default", obs_d(), model(CFG_D, k_r, adv_r));
    check_obs("model_medium",  obs_m(), model(CFG_M, k_r, adv_r));
    check_obs("model_small",   obs_s(), model(CFG_S, k_r, adv_r));
  endtask

  task automatic step();
    @(posedge clk_25MHz);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    pix_en_s = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Continuous run; toggle=1 advances only on every other clock.
  task automatic run_periods(int n, bit toggle, int line_period, int frame_m_period);
    longint cyc = 0, last_ls_d = -1, last_fs_m = -1, last_fs_s = -1;
    int n_ls_d = 0, n_fs_s = 0;
    for (int i = 0; i < n; i++) begin
      pix_en_s = toggle ? ((i % 2) == 0) : 1'b1;
      step();
      cyc++;
      if (if_d.line_start) begin
        if (last_ls_d >= 0) check_int("line_period_default", cyc - last_ls_d, line_period);
        last_ls_d = cyc;
        n_ls_d++;
      end
      if (if_m.frame_start) begin
        if (last_fs_m >= 0) check_int("frame_period_medium", cyc - last_fs_m, frame_m_period);
        last_fs_m = cyc;
      end
      if (if_s.frame_start) begin
        if (last_fs_s >= 0) check_int("frame_period_small", cyc - last_fs_s, toggle ? 80 : 40);
        check_int("frame_count_seq_small", if_s.frame_count, n_fs_s % 256);
        last_fs_s = cyc;
        n_fs_s++;
      end
    end
    check_int("line_start_events_default", n_ls_d, toggle ? (n + 1599) / 1600 : (n + 799) / 800);
    if (!toggle) check_int("frame_start_events_small", n_fs_s, (n + 39) / 40);
  endtask

  initial begin
    // Small instance: H 4/1/2/1, V 2/1/1/1, both syncs active-high.
    vecs[0]  = '{1'b0, 1'b1, mk(7, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 255)};
    vecs[1]  = '{1'b1, 1'b1, mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0)};
    vecs[2]  = '{1'b1, 1'b0, mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)};
    vecs[3]  = '{1'b1, 1'b1, mk(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)};
    vecs[4]  = '{1'b1, 1'b1, mk(2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)};
    vecs[5]  = '{1'b1, 1'b1, mk(3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)};
    vecs[6]  = '{1'b1, 1'b1, mk(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
    vecs[7]  = '{1'b1, 1'b1, mk(5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
    vecs[8]  = '{1'b1, 1'b0, mk(5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
    vecs[9]  = '{1'b1, 1'b1, mk(6, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
    vecs[10] = '{1'b1, 1'b1, mk(7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
    vecs[11] = '{1'b1, 1'b1, mk(0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0)};

    #1;
    for (int i = 0; i < 12; i++) begin
      rst_n    = vecs[i].rst_n;
      pix_en_s = vecs[i].pix_en;
      step();
      check_obs($sformatf("table_small[%0d]", i), obs_s(), vecs[i].exp);
    end

    // Default reset values, independent of the model.
    do_reset();
    check_obs("reset_default", obs_d(), mk(799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 255));

    // Continuous advance: 256+ small frames, two medium frames, many default lines.
    run_periods(10242, 1'b0, 800, 4200);
    check_int("frame_count_wrap_small", if_s.frame_count, 0);

    // Half-rate advance.
    do_reset();
    run_periods(3400, 1'b1, 1600, 8400);

    // Randomised pix_en against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pix_en_s = ($urandom_range(0, 99) < 70);
      step();
    end

    // Asynchronous reset mid-frame on the medium instance at (3,200).
    do_reset();
    for (int i = 0; i < 1604; i++) begin
      pix_en_s = 1'b1;
      step();
    end
    check_int("mid_pos_h_medium", if_m.h_count, 3);
    check_int("mid_pos_v_medium", if_m.v_count, 200);
    #3;
    rst_n = 1'b0;
    #1;
    check_obs("async_reset_medium", obs_m(), mk(7, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 255));
    rst_n    = 1'b1;
    pix_en_s = 1'b1;
    step();
    check_obs("after_reset_medium", obs_m(), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));
    pix_en_s = 1'b0;
    step();
    check_obs("strobe_one_clk_medium", obs_m(), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
